// File: rtl/cu_pkg.sv
// Shared types and ALU control encodings for the multi-cycle control unit.
package cu_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_LOAD  = 3'b100,
    OP_STORE = 3'b101,
    OP_JUMP  = 3'b110,
    OP_BLT   = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic       ALU_INV_B = 1'b1;

  // The four register-register ops occupy the lower half of the opcode space.
  function automatic logic is_alu_op(input opcode_t op);
    return (op[2] == 1'b0);
  endfunction

  // Returns {alu_ctrl, alu_ctrl2}; SUB is ADD with operand B inverted.
  function automatic logic [3:0] alu_controls(input opcode_t op);
    logic [3:0] ctl;
    ctl = {1'b0, ALU_ADD};
    case (op)
      OP_AND:  ctl = {1'b0, ALU_AND};
      OP_OR:   ctl = {1'b0, ALU_OR};
      OP_ADD:  ctl = {1'b0, ALU_ADD};
      OP_SUB:  ctl = {ALU_INV_B, ALU_ADD};
      default: ctl = {1'b0, ALU_ADD};
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational extraction of the instruction fields held in the IR.
module instr_field_decode
  import cu_pkg::*;
#(
  parameter int INSTR_W    = 16,
  parameter int REG_ADDR_W = 3,
  parameter int MEM_ADDR_W = 10
) (
  input  logic [INSTR_W-1:0]    ir,
  output opcode_t               opcode,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [INSTR_W-4:0]    jump_target
);

  assign opcode      = opcode_t'(ir[INSTR_W-1 -: 3]);
  assign rd          = ir[INSTR_W-4 -: REG_ADDR_W];
  assign rs1         = ir[INSTR_W-4-REG_ADDR_W -: REG_ADDR_W];
  assign rs2         = ir[INSTR_W-4-2*REG_ADDR_W -: REG_ADDR_W];
  assign mem_addr    = ir[MEM_ADDR_W-1:0];
  assign jump_target = ir[INSTR_W-4:0];

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with an internal IR,
// a registered negative flag for BLT and a bounded data-memory wait.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int INSTR_W     = 16,
  parameter int REG_ADDR_W  = 3,
  parameter int MEM_ADDR_W  = 10,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  instr_req,
  input  logic                  instr_valid,
  input  logic [INSTR_W-1:0]    instruction,
  input  logic                  alu_negative,
  input  logic                  mem_ready,
  output logic                  alu_ctrl,
  output logic [2:0]            alu_ctrl2,
  output logic                  reg_write_enable,
  output logic                  wb_sel,
  output logic                  mem_req,
  output logic                  mem_write_enable,
  output logic [REG_ADDR_W-1:0] write_address,
  output logic [REG_ADDR_W-1:0] read_address1,
  output logic [REG_ADDR_W-1:0] read_address2,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic [INSTR_W-4:0]    jump_address,
  output logic                  pc_load,
  output logic                  pc_inc,
  output logic                  mem_error
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t               state_reg, state_next;
  logic [INSTR_W-1:0]   ir_reg, ir_next;
  logic                 neg_flag_reg, neg_flag_next;
  logic [CNT_W-1:0]     tmo_cnt_reg, tmo_cnt_next;

  opcode_t               opcode;
  logic [REG_ADDR_W-1:0] rd, rs1, rs2;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [INSTR_W-4:0]    jump_target;
  logic                  timeout_hit;

  instr_field_decode #(
    .INSTR_W    (INSTR_W),
    .REG_ADDR_W (REG_ADDR_W),
    .MEM_ADDR_W (MEM_ADDR_W)
  ) u_fields (
    .ir          (ir_reg),
    .opcode      (opcode),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .mem_addr    (mem_addr),
    .jump_target (jump_target)
  );

  // A zero MEM_TIMEOUT means the MEM state waits indefinitely.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (tmo_cnt_reg == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= FETCH;
      ir_reg       <= '0;
      neg_flag_reg <= 1'b0;
      tmo_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      ir_reg       <= ir_next;
      neg_flag_reg <= neg_flag_next;
      tmo_cnt_reg  <= tmo_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ir_next       = ir_reg;
    neg_flag_next = neg_flag_reg;
    tmo_cnt_next  = tmo_cnt_reg;
    case (state_reg)
      FETCH: begin
        if (instr_valid) begin
          ir_next    = instruction;
          state_next = DECODE;
        end
      end
      DECODE: state_next = EXECUTE;
      EXECUTE: begin
        if (is_alu_op(opcode)) begin
          neg_flag_next = alu_negative;
          state_next    = WRITEBACK;
        end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
          tmo_cnt_next = '0;
          state_next   = MEM;
        end else begin
          state_next = FETCH;
        end
      end
      MEM: begin
        // A completion in the last allowed cycle takes priority over the abort.
        if (mem_ready) begin
          state_next = (opcode == OP_LOAD) ? WRITEBACK : FETCH;
        end else if (timeout_hit) begin
          state_next = FETCH;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end
      WRITEBACK: state_next = FETCH;
      default:   state_next = FETCH;
    endcase
  end

  always_comb begin
    instr_req        = 1'b0;
    pc_inc           = 1'b0;
    pc_load          = 1'b0;
    jump_address     = '0;
    read_address1    = '0;
    read_address2    = '0;
    write_address    = '0;
    alu_ctrl         = 1'b0;
    alu_ctrl2        = '0;
    reg_write_enable = 1'b0;
    wb_sel           = 1'b0;
    mem_req          = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_error        = 1'b0;
    // Reset masks every output so an in-flight access is dropped at once.
    if (!reset) begin
      case (state_reg)
        FETCH: begin
          instr_req = 1'b1;
          pc_inc    = instr_valid;
        end
        DECODE: begin
          read_address1 = (opcode == OP_STORE) ? rd : rs1;
          read_address2 = rs2;
          write_address = rd;
        end
        EXECUTE: begin
          if (is_alu_op(opcode)) begin
            {alu_ctrl, alu_ctrl2} = alu_controls(opcode);
          end else if (opcode == OP_JUMP) begin
            pc_load      = 1'b1;
            jump_address = jump_target;
          end else if (opcode == OP_BLT) begin
            pc_load      = neg_flag_reg;
            jump_address = jump_target;
          end
        end
        MEM: begin
          mem_req          = 1'b1;
          mem_address      = mem_addr;
          mem_write_enable = (opcode == OP_STORE);
          if (opcode == OP_STORE) read_address1 = rd;
          mem_error        = timeout_hit && !mem_ready;
        end
        WRITEBACK: begin
          reg_write_enable = 1'b1;
          write_address    = rd;
          wb_sel           = (opcode == OP_LOAD);
          if (is_alu_op(opcode)) {alu_ctrl, alu_ctrl2} = alu_controls(opcode);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed plus randomized instruction stream checked cycle by cycle against a
// trace built from the per-phase behaviour of each instruction class.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic        instr_req;
    logic        pc_inc;
    logic        pc_load;
    logic [12:0] jump_address;
    logic [2:0]  read_address1;
    logic [2:0]  read_address2;
    logic [2:0]  write_address;
    logic        alu_ctrl;
    logic [2:0]  alu_ctrl2;
    logic        reg_write_enable;
    logic        wb_sel;
    logic        mem_req;
    logic        mem_write_enable;
    logic [9:0]  mem_address;
    logic        mem_error;
  } outs_t;

  typedef struct {
    outs_t o;
    logic  iv;
    logic  mr;
    string tag;
  } step_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req, instr_valid, alu_negative, mem_ready;
  logic [15:0] instruction;
  logic        alu_ctrl, reg_write_enable, wb_sel, mem_req, mem_write_enable;
  logic [2:0]  alu_ctrl2, write_address, read_address1, read_address2;
  logic [9:0]  mem_address;
  logic [12:0] jump_address;
  logic        pc_load, pc_inc, mem_error;
  outs_t       dut_o;

  int    checks = 0;
  int    errors = 0;
  logic  model_neg = 1'b0;
  step_t q[$];

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .INSTR_W(16), .REG_ADDR_W(3), .MEM_ADDR_W(10), .MEM_TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset), .instr_req(instr_req), .instr_valid(instr_valid),
    .instruction(instruction), .alu_negative(alu_negative), .mem_ready(mem_ready),
    .alu_ctrl(alu_ctrl), .alu_ctrl2(alu_ctrl2), .reg_write_enable(reg_write_enable),
    .wb_sel(wb_sel), .mem_req(mem_req), .mem_write_enable(mem_write_enable),
    .write_address(write_address), .read_address1(read_address1),
    .read_address2(read_address2), .mem_address(mem_address),
    .jump_address(jump_address), .pc_load(pc_load), .pc_inc(pc_inc),
    .mem_error(mem_error)
  );

  assign dut_o = {instr_req, pc_inc, pc_load, jump_address, read_address1, read_address2,
                  write_address, alu_ctrl, alu_ctrl2, reg_write_enable, wb_sel, mem_req,
                  mem_write_enable, mem_address, mem_error};

  task automatic check(input outs_t got, input outs_t exp, input string tag);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic noise();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input outs_t o, input logic iv, input logic mr, input string tag);
    step_t s;
    s.o = o; s.iv = iv; s.mr = mr; s.tag = tag;
    q.push_back(s);
  endfunction

  // Builds the expected cycle trace of one instruction; mw is the MEM cycle
  // (0-based) in which mem_ready rises, anything >= 15 never completes.
  task automatic gen(input logic [15:0] ins, input int fw, input int mw, input logic neg);
    logic [2:0] op, rd, rs1, rs2, ctl2;
    logic       inv, done;
    outs_t      o;
    op = ins[15:13]; rd = ins[12:10]; rs1 = ins[9:7]; rs2 = ins[6:4];
    inv  = (op == 3'd3);
    ctl2 = (op == 3'd0) ? 3'b000 : (op == 3'd1) ? 3'b001 : 3'b010;
    done = 1'b0;
    for (int i = 0; i < fw; i++) begin
      o = '0; o.instr_req = 1'b1;
      push(o, 1'b0, noise(), "fetch_wait");
    end
    o = '0; o.instr_req = 1'b1; o.pc_inc = 1'b1;
    push(o, 1'b1, noise(), "fetch");
    o = '0;
    o.read_address1 = (op == 3'd5) ? rd : rs1;
    o.read_address2 = rs2;
    o.write_address = rd;
    push(o, noise(), noise(), "decode");
    o = '0;
    if (op < 3'd4) begin
      o.alu_ctrl = inv; o.alu_ctrl2 = ctl2;
    end else if (op == 3'd6) begin
      o.pc_load = 1'b1; o.jump_address = ins[12:0];
    end else if (op == 3'd7) begin
      o.pc_load = model_neg; o.jump_address = ins[12:0];
    end
    push(o, noise(), noise(), "execute");
    if (op < 3'd4) model_neg = neg;
    if (op == 3'd4 || op == 3'd5) begin
      for (int k = 0; k < 15; k++) begin
        o = '0; o.mem_req = 1'b1; o.mem_address = ins[9:0];
        o.mem_write_enable = (op == 3'd5);
        if (op == 3'd5) o.read_address1 = rd;
        if (k == mw) begin
          push(o, noise(), 1'b1, "mem_ready");
          done = 1'b1;
          break;
        end else if (k == 14) begin
          o.mem_error = 1'b1;
          push(o, noise(), 1'b0, "mem_timeout");
          break;
        end else begin
          push(o, noise(), 1'b0, "mem_wait");
        end
      end
    end
    if (op < 3'd4 || (op == 3'd4 && done)) begin
      o = '0; o.reg_write_enable = 1'b1; o.write_address = rd; o.wb_sel = (op == 3'd4);
      if (op < 3'd4) begin
        o.alu_ctrl = inv; o.alu_ctrl2 = ctl2;
      end
      push(o, noise(), noise(), "writeback");
    end
  endtask

  // Entered at a falling edge; drives one trace step per cycle.
  task automatic run_queue(input int n);
    step_t s;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      s = q.pop_front();
      instr_valid = s.iv;
      mem_ready   = s.mr;
      #1;
      check(dut_o, s.o, s.tag);
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input logic [15:0] ins, input int fw, input int mw, input logic neg);
    int n;
    instruction  = ins;
    alu_negative = neg;
    q.delete();
    gen(ins, fw, mw, neg);
    n = q.size();
    run_queue(n);
    $display("instr %h op=%0d fetch_wait=%0d mem_wait=%0d alu_neg=%0b cycles=%0d",
             ins, ins[15:13], fw, mw, neg, n);
  endtask

  initial begin
    outs_t o;
    logic [15:0] ins;
    int mw;
    reset = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0;
    alu_negative = 1'b0; instruction = 16'h4530;
    repeat (2) @(negedge clk);
    instr_valid = 1'b1; mem_ready = 1'b1;
    #1 check(dut_o, '0, "reset_outputs");
    @(negedge clk);
    instr_valid = 1'b0; mem_ready = 1'b0; reset = 1'b0; model_neg = 1'b0;

    run_instr(16'h4530, 0, 0, 1'b0);     // ADD
    run_instr(16'h9155, 0, 3, 1'b0);     // LOAD, ready after 3 wait cycles
    run_instr(16'hB7FF, 0, 1000, 1'b0);  // STORE, timeout
    run_instr(16'h78A0, 1, 0, 1'b1);     // SUB negative
    run_instr(16'hE010, 0, 0, 1'b0);     // BLT taken
    run_instr(16'h78A0, 0, 0, 1'b0);     // SUB non-negative
    run_instr(16'hE010, 2, 0, 1'b1);     // BLT not taken
    run_instr(16'hCABC, 0, 0, 1'b0);     // JUMP
    run_instr(16'h9155, 0, 14, 1'b0);    // LOAD, ready in final cycle
    run_instr(16'h78A0, 0, 0, 1'b1);     // SUB negative, then reset clears flag

    // LOAD interrupted by reset in its third MEM cycle.
    instruction = 16'h9155;
    q.delete();
    gen(16'h9155, 0, 1000, 1'b0);
    run_queue(5);
    q.delete();
    mem_ready = 1'b0;
    o = '0; o.mem_req = 1'b1; o.mem_address = 10'h155;
    #1 check(dut_o, o, "pre_reset_mem");
    #1 reset = 1'b1;
    #1 check(dut_o, '0, "reset_async");
    @(posedge clk);
    #1 check(dut_o, '0, "reset_held");
    @(negedge clk);
    reset = 1'b0; model_neg = 1'b0;
    run_instr(16'hE010, 0, 0, 1'b0);     // BLT after reset: flag cleared

    for (int t = 0; t < 200; t++) begin
      ins = 16'($urandom);
      mw  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(0, 3));
      run_instr(ins, int'($urandom_range(0, 2)), mw, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
